// File: rtl/scroll_ctrl_pkg.sv
// rtl/scroll_ctrl_pkg.sv - shared stream field layout, opcodes and state encodings for scroll_ctrl
//
// Purpose: common definitions imported by scroll_ctrl and scroll_accum.
//   Pixel stream word (26 bits): [25:20] colour payload, [19:10] YC, [9:0] XC.
//   Opcodes and FSM state encodings match the values exposed on cmd_op / state.
package scroll_ctrl_pkg;

    localparam int STR_W  = 26;
    localparam int XC_LSB = 0;
    localparam int XC_W   = 10;
    localparam int YC_LSB = 10;
    localparam int YC_W   = 10;
    localparam int DISP_W = 10;

    typedef enum logic [1:0] {
        SC_OP_START     = 2'b00,
        SC_OP_STOP      = 2'b01,
        SC_OP_SET_SPEED = 2'b10,
        SC_OP_HOME      = 2'b11
    } sc_op_e;

    typedef enum logic [1:0] {
        SC_ST_STOPPED = 2'b00,
        SC_ST_ACCEL   = 2'b01,
        SC_ST_CRUISE  = 2'b10,
        SC_ST_DECEL   = 2'b11
    } sc_state_e;

    function automatic logic [XC_W-1:0] stream_xc(input logic [STR_W-1:0] s);
        return s[XC_LSB +: XC_W];
    endfunction

    function automatic logic [YC_W-1:0] stream_yc(input logic [STR_W-1:0] s);
        return s[YC_LSB +: YC_W];
    endfunction

endpackage

// File: rtl/scroll_accum.sv
// rtl/scroll_accum.sv - per-frame displacement accumulator with modulo-WRAP wrap
//
// Purpose: at each end-of-frame, disp += speed (mod WRAP) or disp is forced to 0 on home.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   eof               end-of-frame strobe (update enable)
//   home              force disp to 0 on this eof (no wrap reported)
//   speed             px/frame added this eof (speed in effect before the update)
//   disp              registered displacement, 0..WRAP-1
//   wrap_pulse        1-cycle flag, high in the cycle after an eof that wrapped
module scroll_accum
    import scroll_ctrl_pkg::*;
#(
    parameter int WRAP    = 640,
    parameter int SPEED_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               eof,
    input  logic               home,
    input  logic [SPEED_W-1:0] speed,
    output logic [DISP_W-1:0]  disp,
    output logic               wrap_pulse
);

    // One extra bit holds disp + speed before the modulo correction; since
    // speed < WRAP a single conditional subtract is enough.
    logic [DISP_W:0] sum;

    assign sum = {1'b0, disp} + (DISP_W + 1)'(speed);

    always_ff @(posedge clk) begin
        if (reset) begin
            disp       <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (eof) begin
                if (home) begin
                    disp <= '0;
                end else if (sum >= (DISP_W + 1)'(WRAP)) begin
                    disp       <= DISP_W'(sum - (DISP_W + 1)'(WRAP));
                    wrap_pulse <= 1'b1;
                end else begin
                    disp <= sum[DISP_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/scroll_ctrl.sv
// rtl/scroll_ctrl.sv - frame-synchronous scroll speed sequencer (top)
//
// Purpose: accepts START/STOP/SET_SPEED/HOME commands, ramps scroll speed one step
//   per frame toward the target and produces the per-frame X displacement.
//   All state changes happen on the end-of-visible-frame cycle.
// Ports:
//   px_clk, reset       pixel clock, synchronous active-high reset
//   RGBStr_i[25:0]      pixel stream; only XC/YC are used to detect end of frame
//   cmd_valid/cmd_ready command handshake; one command held pending until next eof
//   cmd_op[1:0]         00 START, 01 STOP, 10 SET_SPEED, 11 HOME
//   cmd_speed           operand for SET_SPEED
//   disp[9:0]           displacement, 0..WRAP-1
//   cur_speed           speed in effect
//   state[1:0]          00 STOPPED, 01 ACCEL, 10 CRUISE, 11 DECEL
//   frame_pulse         1-cycle pulse in the cycle after each eof update
//   wrap_pulse          1-cycle pulse with frame_pulse when disp wrapped
module scroll_ctrl
    import scroll_ctrl_pkg::*;
#(
    parameter int VISIBLECOLS   = 640,
    parameter int VISIBLEROWS   = 480,
    parameter int TAB_XSIZE     = 40,
    parameter int TILE_W        = 16,
    parameter int SPEED_W       = 4,
    parameter int SPEED_MAX     = 15,
    parameter int RAMP_STEP     = 1,
    parameter int DEFAULT_SPEED = 1
) (
    input  logic               px_clk,
    input  logic               reset,
    input  logic [STR_W-1:0]   RGBStr_i,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [SPEED_W-1:0] cmd_speed,
    output logic [DISP_W-1:0]  disp,
    output logic [SPEED_W-1:0] cur_speed,
    output logic [1:0]         state,
    output logic               frame_pulse,
    output logic               wrap_pulse
);

    localparam int WRAP = TAB_XSIZE * TILE_W;

    localparam logic [SPEED_W-1:0] STEP  = SPEED_W'(RAMP_STEP);
    localparam logic [SPEED_W-1:0] SPMAX = SPEED_W'(SPEED_MAX);

    sc_state_e          state_q, state_n, state_mid;
    logic [SPEED_W-1:0] cur_q, cur_n;
    logic [SPEED_W-1:0] tgt_q, tgt_n;
    logic [SPEED_W-1:0] set_q, set_n;
    logic               pend_valid;
    sc_op_e             pend_op;
    logic [SPEED_W-1:0] pend_speed;
    logic               home;
    logic               eof;
    logic               unused_rgb;

    assign eof = (stream_xc(RGBStr_i) == XC_W'(VISIBLECOLS - 1)) &&
                 (stream_yc(RGBStr_i) == YC_W'(VISIBLEROWS - 1));

    assign unused_rgb = ^RGBStr_i[STR_W-1:YC_LSB+YC_W];

    assign cmd_ready = !pend_valid;
    assign cur_speed = cur_q;
    assign state     = state_q;

    function automatic sc_state_e eval_state(input logic [SPEED_W-1:0] cur,
                                             input logic [SPEED_W-1:0] tgt);
        if (cur < tgt)      return SC_ST_ACCEL;
        else if (cur > tgt) return SC_ST_DECEL;
        else if (tgt == '0) return SC_ST_STOPPED;
        else                return SC_ST_CRUISE;
    endfunction

    // Move cur one RAMP_STEP toward tgt without overshooting it.
    function automatic logic [SPEED_W-1:0] ramp(input logic [SPEED_W-1:0] cur,
                                                input logic [SPEED_W-1:0] tgt);
        if (cur < tgt)      return ((tgt - cur) > STEP) ? cur + STEP : tgt;
        else if (cur > tgt) return ((cur - tgt) > STEP) ? cur - STEP : tgt;
        else                return cur;
    endfunction

    // Pending command: cleared by the eof that applies it. A command accepted on
    // an eof cycle finds the register empty, so it waits for the following eof.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_op    <= SC_OP_START;
            pend_speed <= '0;
        end else if (eof && pend_valid) begin
            pend_valid <= 1'b0;
        end else if (cmd_valid && cmd_ready) begin
            pend_valid <= 1'b1;
            pend_op    <= sc_op_e'(cmd_op);
            pend_speed <= cmd_speed;
        end
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            state_q     <= SC_ST_STOPPED;
            cur_q       <= '0;
            tgt_q       <= '0;
            set_q       <= SPEED_W'(DEFAULT_SPEED);
            frame_pulse <= 1'b0;
        end else begin
            state_q     <= state_n;
            cur_q       <= cur_n;
            tgt_q       <= tgt_n;
            set_q       <= set_n;
            frame_pulse <= eof;
        end
    end

    always_comb begin
        state_n   = state_q;
        state_mid = state_q;
        cur_n     = cur_q;
        tgt_n     = tgt_q;
        set_n     = set_q;
        home      = 1'b0;
        if (eof) begin
            // Step 1: apply the pending command.
            if (pend_valid) begin
                case (pend_op)
                    SC_OP_START: begin
                        tgt_n     = set_q;
                        state_mid = eval_state(cur_q, set_q);
                    end
                    SC_OP_STOP: begin
                        if (state_q != SC_ST_STOPPED) begin
                            tgt_n     = '0;
                            state_mid = SC_ST_DECEL;
                        end
                    end
                    SC_OP_SET_SPEED: begin
                        set_n = (pend_speed > SPMAX) ? SPMAX : pend_speed;
                        if (state_q != SC_ST_STOPPED) begin
                            tgt_n     = set_n;
                            state_mid = eval_state(cur_q, set_n);
                        end
                    end
                    default: home = 1'b1;
                endcase
            end
            // Step 2 (disp update with the old speed) lives in scroll_accum.
            // Step 3: ramp and settle the state once the target is reached.
            cur_n = ramp(cur_q, tgt_n);
            if (cur_n == tgt_n) state_n = (tgt_n != '0) ? SC_ST_CRUISE : SC_ST_STOPPED;
            else                state_n = state_mid;
        end
    end

    scroll_accum #(
        .WRAP    (WRAP),
        .SPEED_W (SPEED_W)
    ) u_accum (
        .clk        (px_clk),
        .reset      (reset),
        .eof        (eof),
        .home       (home),
        .speed      (cur_q),
        .disp       (disp),
        .wrap_pulse (wrap_pulse)
    );

endmodule

// File: tb/tb_scroll_ctrl.sv
// tb/tb_scroll_ctrl.sv - directed self-checking bench for scroll_ctrl
module tb_scroll_ctrl;

    localparam int ST_STOPPED = 0, ST_ACCEL = 1, ST_CRUISE = 2, ST_DECEL = 3;
    localparam int OP_START = 0, OP_STOP = 1, OP_SET = 2, OP_HOME = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [25:0] rgb;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_speed;
    logic [9:0]  disp;
    logic [3:0]  cur_speed;
    logic [1:0]  state;
    logic        frame_pulse;
    logic        wrap_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scroll_ctrl dut (
        .px_clk      (clk),
        .reset       (reset),
        .RGBStr_i    (rgb),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_speed   (cmd_speed),
        .disp        (disp),
        .cur_speed   (cur_speed),
        .state       (state),
        .frame_pulse (frame_pulse),
        .wrap_pulse  (wrap_pulse)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input int x, input int y);
        rgb = {6'h15, 10'(y), 10'(x)};
    endtask

    // Idle cycles alternate between positions matching only one of XC/YC.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) set_pos(639, 0);
            else            set_pos(5, 479);
            step();
        end
        set_pos(0, 0);
    endtask

    task automatic do_eof();
        set_pos(639, 479);
        step();
        set_pos(0, 0);
    endtask

    task automatic send_cmd(input int op, input int spd);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_speed = 4'(spd);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (disp !== 10'd0) begin errors++; $display("FAIL reset_disp: got %0d expected 0", disp); end
        checks++; if (cur_speed !== 4'd0) begin errors++; $display("FAIL reset_speed: got %0d expected 0", cur_speed); end
        checks++; if (state !== 2'(ST_STOPPED)) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0d expected 1", cmd_ready); end
        checks++; if ({frame_pulse, wrap_pulse} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {frame_pulse, wrap_pulse}); end
    endtask

    task automatic test_start();
        int exp_d[3] = '{0, 1, 2};
        // START accepted on the EOF0 cycle itself.
        set_pos(639, 479);
        cmd_valid = 1'b1; cmd_op = 2'(OP_START); cmd_speed = 4'd0;
        step();
        cmd_valid = 1'b0;
        set_pos(0, 0);
        checks++; if (disp !== 10'd0) begin errors++; $display("FAIL t1_eof0_disp: got %0d expected 0", disp); end
        checks++; if (state !== 2'(ST_STOPPED)) begin errors++; $display("FAIL t1_eof0_state: got %0d expected 0", state); end
        checks++; if (frame_pulse !== 1'b1) begin errors++; $display("FAIL t1_frame_pulse: got %0d expected 1", frame_pulse); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_low: got %0d expected 0", cmd_ready); end
        step();
        checks++; if (frame_pulse !== 1'b0) begin errors++; $display("FAIL t1_frame_pulse_width: got %0d expected 0", frame_pulse); end
        idle(3);
        checks++; if (cur_speed !== 4'd0) begin errors++; $display("FAIL t1_speed_stable: got %0d expected 0", cur_speed); end
        for (int i = 0; i < 3; i++) begin
            do_eof();
            checks++; if (disp !== 10'(exp_d[i])) begin errors++; $display("FAIL t1_disp[%0d]: got %0d expected %0d", i + 1, disp, exp_d[i]); end
            checks++; if (cur_speed !== 4'd1) begin errors++; $display("FAIL t1_speed[%0d]: got %0d expected 1", i + 1, cur_speed); end
            checks++; if (state !== 2'(ST_CRUISE)) begin errors++; $display("FAIL t1_state[%0d]: got %0d expected 2", i + 1, state); end
        end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL t1_ready_back: got %0d expected 1", cmd_ready); end
    endtask

    task automatic test_set_speed();
        int exp_d[3] = '{1, 3, 6};
        int exp_c[3] = '{2, 3, 4};
        int exp_s[3] = '{ST_ACCEL, ST_ACCEL, ST_CRUISE};
        idle(1);
        send_cmd(OP_HOME, 0);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL t2_home_ready: got %0d expected 0", cmd_ready); end
        idle(2);
        checks++; if (disp !== 10'd2) begin errors++; $display("FAIL t2_disp_hold: got %0d expected 2", disp); end
        do_eof();
        checks++; if (disp !== 10'd0) begin errors++; $display("FAIL t2_home_disp: got %0d expected 0", disp); end
        checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL t2_home_wrap: got %0d expected 0", wrap_pulse); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_after_eof: got %0d expected 1", cmd_ready); end
        send_cmd(OP_SET, 4);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL t2_set_ready: got %0d expected 0", cmd_ready); end
        for (int i = 0; i < 3; i++) begin
            do_eof();
            checks++; if (disp !== 10'(exp_d[i])) begin errors++; $display("FAIL t2_disp[%0d]: got %0d expected %0d", i, disp, exp_d[i]); end
            checks++; if (cur_speed !== 4'(exp_c[i])) begin errors++; $display("FAIL t2_speed[%0d]: got %0d expected %0d", i, cur_speed, exp_c[i]); end
            checks++; if (state !== 2'(exp_s[i])) begin errors++; $display("FAIL t2_state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
        end
    endtask

    task automatic test_wrap();
        int wraps = 0;
        for (int i = 0; i < 158; i++) begin
            do_eof();
            if (wrap_pulse === 1'b1) wraps++;
        end
        checks++; if (wraps !== 0) begin errors++; $display("FAIL t3_early_wraps: got %0d expected 0", wraps); end
        checks++; if (disp !== 10'd638) begin errors++; $display("FAIL t3_disp_pre: got %0d expected 638", disp); end
        do_eof();
        checks++; if (disp !== 10'd2) begin errors++; $display("FAIL t3_disp_wrapped: got %0d expected 2", disp); end
        checks++; if ({wrap_pulse, frame_pulse} !== 2'b11) begin errors++; $display("FAIL t3_pulses: got %b expected 11", {wrap_pulse, frame_pulse}); end
        step();
        checks++; if ({wrap_pulse, frame_pulse} !== 2'b00) begin errors++; $display("FAIL t3_pulse_width: got %b expected 00", {wrap_pulse, frame_pulse}); end
    endtask

    task automatic test_eof_accept();
        set_pos(639, 479);
        cmd_valid = 1'b1; cmd_op = 2'(OP_SET); cmd_speed = 4'd2;
        step();
        cmd_valid = 1'b0;
        set_pos(0, 0);
        checks++; if (disp !== 10'd6) begin errors++; $display("FAIL t4_disp: got %0d expected 6", disp); end
        checks++; if ({cur_speed, state} !== {4'd4, 2'(ST_CRUISE)}) begin errors++; $display("FAIL t4_not_applied: got speed %0d state %0d expected speed 4 state 2", cur_speed, state); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL t4_ready: got %0d expected 0", cmd_ready); end
        idle(2);
        do_eof();
        checks++; if ({disp, cur_speed, state} !== {10'd10, 4'd3, 2'(ST_DECEL)}) begin errors++; $display("FAIL t4_applied: got disp %0d speed %0d state %0d expected 10 3 3", disp, cur_speed, state); end
        send_cmd(OP_SET, 4);
        do_eof();
        checks++; if ({disp, cur_speed, state} !== {10'd13, 4'd4, 2'(ST_CRUISE)}) begin errors++; $display("FAIL t4_reaccel: got disp %0d speed %0d state %0d expected 13 4 2", disp, cur_speed, state); end
    endtask

    task automatic test_stop();
        int exp_d[6] = '{17, 20, 22, 23, 23, 23};
        int exp_c[6] = '{3, 2, 1, 0, 0, 0};
        int exp_s[6] = '{ST_DECEL, ST_DECEL, ST_DECEL, ST_STOPPED, ST_STOPPED, ST_STOPPED};
        send_cmd(OP_STOP, 0);
        for (int i = 0; i < 6; i++) begin
            do_eof();
            checks++; if ({disp, cur_speed, state} !== {10'(exp_d[i]), 4'(exp_c[i]), 2'(exp_s[i])}) begin
                errors++;
                $display("FAIL t5_decel[%0d]: got disp %0d speed %0d state %0d expected %0d %0d %0d", i, disp, cur_speed, state, exp_d[i], exp_c[i], exp_s[i]);
            end
        end
        send_cmd(OP_HOME, 0);
        do_eof();
        checks++; if ({disp, wrap_pulse, state} !== {10'd0, 1'b0, 2'(ST_STOPPED)}) begin errors++; $display("FAIL t5_home: got disp %0d wrap %0d state %0d expected 0 0 0", disp, wrap_pulse, state); end
        send_cmd(OP_SET, 3);
        do_eof();
        checks++; if ({cur_speed, state} !== {4'd0, 2'(ST_STOPPED)}) begin errors++; $display("FAIL t5_set_while_stopped: got speed %0d state %0d expected 0 0", cur_speed, state); end
        send_cmd(OP_START, 0);
        do_eof();
        checks++; if ({disp, cur_speed, state} !== {10'd0, 4'd1, 2'(ST_ACCEL)}) begin errors++; $display("FAIL t5_restart: got disp %0d speed %0d state %0d expected 0 1 1", disp, cur_speed, state); end
        do_eof();
        checks++; if ({disp, cur_speed, state} !== {10'd1, 4'd2, 2'(ST_ACCEL)}) begin errors++; $display("FAIL t5_ramp: got disp %0d speed %0d state %0d expected 1 2 1", disp, cur_speed, state); end
    endtask

    task automatic test_reset_mid();
        send_cmd(OP_STOP, 0);
        do_eof();
        checks++; if ({disp, cur_speed, state} !== {10'd3, 4'd1, 2'(ST_DECEL)}) begin errors++; $display("FAIL t6_decel: got disp %0d speed %0d state %0d expected 3 1 3", disp, cur_speed, state); end
        send_cmd(OP_START, 0);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL t6_pending: got %0d expected 0", cmd_ready); end
        idle(1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({disp, cur_speed, state, cmd_ready, frame_pulse, wrap_pulse} !== {10'd0, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL t6_reset_values: got disp %0d speed %0d state %0d ready %0d fp %0d wp %0d expected 0 0 0 1 0 0", disp, cur_speed, state, cmd_ready, frame_pulse, wrap_pulse);
        end
        do_eof();
        checks++; if ({disp, cur_speed, state} !== {10'd0, 4'd0, 2'(ST_STOPPED)}) begin errors++; $display("FAIL t6_pending_lost: got disp %0d speed %0d state %0d expected 0 0 0", disp, cur_speed, state); end
        send_cmd(OP_START, 0);
        do_eof();
        checks++; if ({cur_speed, state} !== {4'd1, 2'(ST_CRUISE)}) begin errors++; $display("FAIL t6_default_speed: got speed %0d state %0d expected 1 2", cur_speed, state); end
        do_eof();
        checks++; if (disp !== 10'd1) begin errors++; $display("FAIL t6_disp: got %0d expected 1", disp); end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_speed = 4'd0;
        rgb       = '0;
        test_reset();
        test_start();
        test_set_speed();
        test_wrap();
        test_eof_accept();
        test_stop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
